ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 22 ++
 rtl/burst_counter.sv | 25 ++
 rtl/ram_arbiter.sv | 114 +++++++++++
 tb/tb_ram_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM port-A arbiter: owner encodings and defaults.
package ram_arbiter_pkg;

  // Who held port A in the previous cycle.
  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  // Default cap on consecutive locked DMA beats while the CPU is waiting.
  localparam int MAX_BURST_DEF = 8;

  // Byte-enable width of both requesters and of the RAM port.
  localparam int WE_W = 4;

  // Counter width able to hold 0..max inclusive.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/burst_counter.sv
// Saturating beat counter: counts up on inc, holds at MAX, clears on clr.
module burst_counter #(
  parameter int MAX = 8,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic         sat,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  // clr has priority; increments stop once the cap is reached
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              cnt <= '0;
    else if (clr)           cnt <= '0;
    else if (inc && !sat)   cnt <= cnt + W'(1);
  end

  assign sat = (cnt == MAX_C);

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for RAM port A: CPU-priority with a bounded DMA lock.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  // memory-stage requester
  input  logic              cpu_req,
  input  logic [WE_W-1:0]   cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  // loader / DMA requester
  input  logic              dma_req,
  input  logic              dma_lock,
  input  logic [WE_W-1:0]   dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  // shared read data
  output logic [DATA_W-1:0] rdata,
  // RAM port A
  output logic [WE_W-1:0]   ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = cnt_width(MAX_BURST);

  owner_t            owner, owner_nxt;
  logic [CNT_W-1:0]  burst_cnt;
  logic              burst_sat;
  logic              lock_hold;

  // Consecutive DMA grant counter; any non-DMA cycle restarts the run.
  burst_counter #(
    .MAX (MAX_BURST),
    .W   (CNT_W)
  ) u_burst (
    .clk   (clk),
    .reset (reset),
    .inc   (dma_gnt),
    .clr   (!dma_gnt),
    .sat   (burst_sat),
    .cnt   (burst_cnt)
  );

  // Owner register: remembers last cycle's grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) owner <= OWN_IDLE;
    else       owner <= owner_nxt;
  end

  // Grant decision and next owner. Lock only counts while DMA already
  // owns the port and the run is below the cap, so a waiting CPU always
  // gets a slot once the cap is hit.
  always_comb begin
    lock_hold = 1'b0;
    dma_gnt   = 1'b0;
    cpu_gnt   = 1'b0;
    owner_nxt = OWN_IDLE;
    if (!reset) begin
      lock_hold = (owner == OWN_DMA) && dma_req && dma_lock && !burst_sat;
      dma_gnt   = dma_req && (!cpu_req || lock_hold);
      cpu_gnt   = cpu_req && !dma_gnt;
    end
    if (cpu_gnt)      owner_nxt = OWN_CPU;
    else if (dma_gnt) owner_nxt = OWN_DMA;
  end

  assign cpu_stall = cpu_req && !cpu_gnt;

  // Port A mux: the winner drives the RAM, otherwise everything is quiet.
  always_comb begin
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (cpu_gnt) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      ram_we    = dma_we;
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
    end
  end

  // Read-valid tags follow the RAM's one-cycle read latency; reset kills
  // any read still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_gnt && (cpu_we == '0);
      dma_rvalid <= dma_gnt && (dma_we == '0);
    end
  end

  assign rdata = ram_rdata;

  // Never two owners in one cycle.
  a_one_gnt: assert property (@(posedge clk) disable iff (reset) !(cpu_gnt && dma_gnt));

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a cycle-level reference model.
module tb_ram_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req = 1'b0, dma_req = 1'b0, dma_lock = 1'b0;
  logic [3:0]    cpu_we = '0, dma_we = '0;
  logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0;
  logic          cpu_gnt, cpu_rvalid, cpu_stall, dma_gnt, dma_rvalid;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;

  int checks = 0;
  int failures = 0;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Synchronous-read RAM with byte enables, preloaded on its first edge.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
      mem[9'h004] <= 32'hDEADBEEF;
      mem[9'h100] <= 32'h12345678;
      ram_init <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  // ---------------- reference model ----------------
  // m_last: 0 none, 1 cpu, 2 dma granted last cycle; m_run: length of the
  // current unbroken run of DMA grants (unbounded integer).
  int            m_last = 0, m_run = 0;
  bit            m_pc = 0, m_pd = 0;
  logic [DW-1:0] m_pdata = '0;
  int            n_last = 0, n_run = 0;
  bit            n_pc = 0, n_pd = 0, n_wr = 0;
  logic [DW-1:0] n_pdata = '0, n_wd = '0;
  logic [AW-1:0] n_wa = '0;
  logic [3:0]    n_wbe = '0;
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  bit            sh_init = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      if (!sh_init) begin
        for (int i = 0; i < (1<<AW); i++) shadow[i] <= '0;
        shadow[9'h004] <= 32'hDEADBEEF;
        shadow[9'h100] <= 32'h12345678;
        sh_init <= 1'b1;
      end
      m_last <= 0; m_run <= 0; m_pc <= 0; m_pd <= 0;
    end else begin
      m_last <= n_last; m_run <= n_run; m_pc <= n_pc; m_pd <= n_pd; m_pdata <= n_pdata;
      if (n_wr)
        for (int b = 0; b < 4; b++)
          if (n_wbe[b]) shadow[n_wa][8*b +: 8] <= n_wd[8*b +: 8];
    end
  end

  // Compare process: every mid-cycle, derive what the outputs must be.
  always @(negedge clk) begin
    bit ec, ed;
    logic [3:0]    ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    ec = 0; ed = 0;
    if (!reset) begin
      ed = dma_req && (!cpu_req || (dma_lock && m_last == 2 && m_run < MB));
      ec = cpu_req && !ed;
    end
    ewe = ec ? cpu_we : ed ? dma_we : 4'h0;
    ea  = ec ? cpu_addr : ed ? dma_addr : '0;
    ew  = ec ? cpu_wdata : ed ? dma_wdata : '0;
    chk("m_cpu_gnt",   32'(cpu_gnt),   32'(ec));
    chk("m_dma_gnt",   32'(dma_gnt),   32'(ed));
    chk("m_cpu_stall", 32'(cpu_stall), 32'(cpu_req && !ec));
    chk("m_ram_we",    32'(ram_we),    32'(ewe));
    chk("m_ram_addr",  32'(ram_addr),  32'(ea));
    chk("m_ram_wdata", ram_wdata,      ew);
    chk("m_cpu_rvalid", 32'(cpu_rvalid), 32'(m_pc));
    chk("m_dma_rvalid", 32'(dma_rvalid), 32'(m_pd));
    if (m_pc || m_pd) chk("m_rdata", rdata, m_pdata);
    n_last  = ec ? 1 : ed ? 2 : 0;
    n_run   = ed ? m_run + 1 : 0;
    n_pc    = ec && (cpu_we == 4'h0);
    n_pd    = ed && (dma_we == 4'h0);
    n_pdata = shadow[ea];
    n_wr    = (ec || ed) && (ewe != 4'h0);
    n_wa = ea; n_wd = ew; n_wbe = ewe;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_lock = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  initial begin
    int b, cyc, cpu_cyc, resume_cyc, stalls, cpu_gnts, beats_before;
    bit cpu_done, prev_cpu;

    // reset, with a CPU write pending that must not be granted
    idle();
    #1 reset = 1;
    cpu_req = 1; cpu_we = 4'hF; cpu_addr = 9'h001; cpu_wdata = 32'h55;
    #1;
    chk("rst_owner",   32'(dut.owner), 32'h0);
    chk("rst_cnt",     32'(dut.burst_cnt), 32'h0);
    chk("rst_cpu_rv",  32'(cpu_rvalid), 32'h0);
    chk("rst_dma_rv",  32'(dma_rvalid), 32'h0);
    chk("rst_cpu_gnt", 32'(cpu_gnt), 32'h0);
    chk("rst_ram_we",  32'(ram_we), 32'h0);
    @(posedge clk); @(posedge clk); #1 reset = 0;
    idle();

    // idle port, then lock alone
    @(negedge clk);
    chk("idle_ram_we",   32'(ram_we), 32'h0);
    chk("idle_ram_addr", 32'(ram_addr), 32'h0);
    chk("idle_gnts",     32'({cpu_gnt, dma_gnt}), 32'h0);
    chk("idle_stall",    32'(cpu_stall), 32'h0);
    step();
    dma_lock = 1;
    @(negedge clk);
    chk("lock_only_gnt", 32'({cpu_gnt, dma_gnt}), 32'h0);
    step();

    // simultaneous requests: CPU wins, DMA follows
    idle();
    cpu_req = 1; cpu_addr = 9'h010;
    dma_req = 1; dma_addr = 9'h050;
    @(negedge clk);
    chk("tie_cpu_gnt", 32'(cpu_gnt), 32'h1);
    chk("tie_dma_gnt", 32'(dma_gnt), 32'h0);
    chk("tie_stall",   32'(cpu_stall), 32'h0);
    chk("tie_addr",    32'(ram_addr), 32'h010);
    step();
    cpu_req = 0;
    @(negedge clk);
    chk("tie_cpu_rv",  32'(cpu_rvalid), 32'h1);
    chk("tie_dma_gnt2", 32'(dma_gnt), 32'h1);
    step();
    idle();
    step();

    // locked DMA burst with a forced CPU slot after MAX_BURST beats
    b = 0; cyc = 0; cpu_cyc = -1; resume_cyc = -1; stalls = 0; cpu_gnts = 0;
    beats_before = -1; cpu_done = 0;
    while (b < 16 && cyc < 40) begin
      dma_req = 1; dma_lock = 1; dma_we = 4'hF;
      dma_addr = AW'(9'h020 + b); dma_wdata = 32'hA0 + 32'(b);
      cpu_req = (b >= 3) && !cpu_done; cpu_we = 0; cpu_addr = 9'h021;
      @(negedge clk);
      if (cpu_stall) stalls++;
      if (cpu_gnt) begin
        cpu_gnts++; cpu_done = 1; cpu_cyc = cyc; beats_before = b;
        chk("burst_cnt_at_yield", 32'(dut.burst_cnt), 32'(MB));
      end
      if (cyc == cpu_cyc + 1 && cpu_cyc >= 0) begin
        chk("burst_cpu_rv",    32'(cpu_rvalid), 32'h1);
        chk("burst_cpu_rdata", rdata, 32'hA1);
        if (dma_gnt) resume_cyc = cyc;
      end
      if (dma_gnt) b++;
      cyc++;
      step();
    end
    if (b < 16) chk("burst_timeout", 32'(b), 32'd16);
    chk("burst_beats_before_cpu", 32'(beats_before), 32'(MB));
    chk("burst_cpu_gnts", 32'(cpu_gnts), 32'h1);
    chk("burst_stalls",   32'(stalls), 32'd5);
    chk("burst_resume",   32'(resume_cyc - cpu_cyc), 32'h1);
    idle();
    step();

    // alternating reads, one grant per cycle
    prev_cpu = 0;
    for (int k = 0; k <= 8; k++) begin
      idle();
      if (k < 8) begin
        if (k % 2 == 0) begin cpu_req = 1; cpu_addr = 9'h004; end
        else            begin dma_req = 1; dma_addr = 9'h100; end
      end
      @(negedge clk);
      if (k > 0) begin
        chk("alt_cpu_rv", 32'(cpu_rvalid), 32'(prev_cpu));
        chk("alt_dma_rv", 32'(dma_rvalid), 32'(!prev_cpu));
        chk("alt_rdata", rdata, prev_cpu ? 32'hDEADBEEF : 32'h12345678);
      end
      if (k < 8) chk("alt_gnt", 32'({cpu_gnt, dma_gnt}), (k % 2 == 0) ? 32'h2 : 32'h1);
      prev_cpu = (k % 2 == 0);
      step();
    end
    idle();
    step();

    // reset in the middle of a DMA read's data cycle
    dma_req = 1; dma_addr = 9'h100;
    @(negedge clk);
    chk("rr_dma_gnt", 32'(dma_gnt), 32'h1);
    step();
    dma_req = 0;
    #2 reset = 1;
    #1;
    chk("rr_dma_rv", 32'(dma_rvalid), 32'h0);
    chk("rr_owner",  32'(dut.owner), 32'h0);
    chk("rr_cnt",    32'(dut.burst_cnt), 32'h0);
    step();
    reset = 0;
    cpu_req = 1; cpu_we = 4'hF; cpu_addr = 9'h030; cpu_wdata = 32'hCAFE0001;
    @(negedge clk);
    chk("rr_first_gnt", 32'(cpu_gnt), 32'h1);
    chk("rr_dma_rv2",   32'(dma_rvalid), 32'h0);
    step();
    chk("rr_owner_cpu", 32'(dut.owner), 32'h1);
    idle();
    cpu_req = 1; cpu_addr = 9'h030;
    step();
    idle();
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
